// File: rtl/shot_clock_timer_pkg.sv
// Shared definitions for the shot clock timer and its sibling scoreboard blocks.
package shot_clock_timer_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StPause   = 2'd2,
    StExpired = 2'd3
  } sc_state_e;

  // Default presets, also used by the score/period blocks.
  localparam int unsigned DefaultPresetA = 24;
  localparam int unsigned DefaultPresetB = 14;

endpackage

// File: rtl/shot_clock_timer_tick_prescaler.sv
// Clock divider: one-cycle tick every ClkDiv enabled cycles, with synchronous clear.
module shot_clock_timer_tick_prescaler #(
  parameter int unsigned ClkDiv = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (ClkDiv > 2) ? $clog2(ClkDiv) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ClkDiv - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  // Clear wins over enable; wrap at ClkDiv-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == CntMax);

endmodule

// File: rtl/shot_clock_timer.sv
// Shot clock countdown timer with run/pause, three load sources, buzzer pulse and BCD digits.
module shot_clock_timer
  import shot_clock_timer_pkg::*;
#(
  parameter int unsigned WIDTH      = 7,
  parameter int unsigned PRESET_A   = DefaultPresetA,
  parameter int unsigned PRESET_B   = DefaultPresetB,
  parameter int unsigned CLK_DIV    = 50000000,
  parameter int unsigned BUZZ_TICKS = 2
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             run,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             load_custom,
  input  logic [WIDTH-1:0] custom_value,
  output logic [WIDTH-1:0] count,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             running,
  output logic             expired,
  output logic             buzzer
);

  if (WIDTH < 5 || WIDTH > 7) begin : gen_chk_width
    $error("WIDTH must be in 5..7");
  end
  if (PRESET_A >= (1 << WIDTH) || PRESET_B >= (1 << WIDTH)) begin : gen_chk_preset
    $error("PRESET_A/PRESET_B must fit in WIDTH bits");
  end
  if (CLK_DIV < 2) begin : gen_chk_div
    $error("CLK_DIV must be >= 2");
  end
  if (BUZZ_TICKS < 1) begin : gen_chk_buzz
    $error("BUZZ_TICKS must be >= 1");
  end

  localparam int unsigned BuzzW = (BUZZ_TICKS > 1) ? $clog2(BUZZ_TICKS + 1) : 1;
  localparam logic [WIDTH-1:0] PresetAW = WIDTH'(PRESET_A);
  localparam logic [WIDTH-1:0] PresetBW = WIDTH'(PRESET_B);

  sc_state_e        state_d, state_q;
  logic [WIDTH-1:0] count_d, count_q;
  logic [BuzzW-1:0] buzz_cnt_d, buzz_cnt_q;
  logic             buzzer_d, buzzer_q;
  logic             load_any;
  logic [WIDTH-1:0] load_val;
  logic             pre_en, pre_clr, tick;

  // Prescaler runs while counting down, and after expiry only to time the buzzer.
  assign pre_en = (state_q == StRun) || ((state_q == StExpired) && (buzz_cnt_q != '0));

  shot_clock_timer_tick_prescaler #(
    .ClkDiv(CLK_DIV)
  ) u_prescaler (
    .clk_i  (clock_in),
    .rst_ni (reset_n),
    .en_i   (pre_en),
    .clr_i  (pre_clr),
    .tick_o (tick)
  );

  // Next-state logic: a load overrides everything, including a coincident tick.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    buzz_cnt_d = buzz_cnt_q;
    buzzer_d   = buzzer_q;
    pre_clr    = 1'b0;
    load_any   = load_a | load_b | load_custom;
    load_val   = custom_value;
    if (load_b) load_val = PresetBW;
    if (load_a) load_val = PresetAW;

    if (load_any) begin
      count_d    = load_val;
      pre_clr    = 1'b1;
      buzz_cnt_d = '0;
      buzzer_d   = 1'b0;
      if (load_val == '0) begin
        state_d = StIdle;
      end else if (run) begin
        state_d = StRun;
      end else begin
        state_d = StPause;
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StRun: begin
          if (!run) begin
            state_d = StPause;
          end else if (tick) begin
            if (count_q <= WIDTH'(1)) begin
              count_d    = '0;
              state_d    = StExpired;
              buzzer_d   = 1'b1;
              buzz_cnt_d = BuzzW'(BUZZ_TICKS);
            end else begin
              count_d = count_q - 1'b1;
            end
          end
        end
        StPause: begin
          if (run) state_d = StRun;
        end
        StExpired: begin
          if (tick && (buzz_cnt_q != '0)) begin
            buzz_cnt_d = buzz_cnt_q - 1'b1;
            if (buzz_cnt_q == BuzzW'(1)) buzzer_d = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      buzz_cnt_q <= '0;
      buzzer_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      buzz_cnt_q <= buzz_cnt_d;
      buzzer_q   <= buzzer_d;
    end
  end

  // BCD digits for the display; values above 99 saturate to 9,9.
  always_comb begin
    int unsigned count_int;
    count_int = 32'(count_q);
    tens      = 4'd9;
    ones      = 4'd9;
    if (count_int <= 99) begin
      tens = 4'(count_int / 10);
      ones = 4'(count_int % 10);
    end
  end

  assign count   = count_q;
  assign running = (state_q == StRun);
  assign expired = (state_q == StExpired);
  assign buzzer  = buzzer_q;

endmodule
